// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of the two requester ports and the blockram side
// of the ram_arbiter. The slave modport is the arbiter's view. The master
// modport is the view of whoever drives the requests and models the RAM.
interface ram_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);

    // status
    logic              init_done_o;

    // requester port 0 (CPU data port)
    logic              p0_req_i;
    logic              p0_we_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_wdata_i;
    logic              p0_gnt_o;
    logic              p0_rvalid_o;
    logic [DATA_W-1:0] p0_rdata_o;

    // requester port 1 (host loader / debug port)
    logic              p1_req_i;
    logic              p1_we_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_wdata_i;
    logic              p1_gnt_o;
    logic              p1_rvalid_o;
    logic [DATA_W-1:0] p1_rdata_o;

    // blockram side
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport slave (
        output init_done_o,
        input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        input  init_done_o,
        output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );

endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter and sequencer for a single-port
// blockram (negedge read/write). After reset it zero-fills every RAM word,
// then grants at most one access per cycle to p0 or p1. The RAM controls
// are registered. Read data comes back one cycle after the grant, together
// with a single-cycle valid strobe on the port that asked for it.
//
// Build option RAM_ARB_RR_EN: when defined, ties go round-robin, and the
// port that was not granted last wins. When undefined, p0 has fixed
// priority on ties.
module ram_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_arbiter_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] fill_cnt_q;

    // pending read tag: valid bit plus which port issued it (1 = p1)
    logic              pend_valid_q;
    logic              pend_port_q;

`ifdef RAM_ARB_RR_EN
    // 1 when p1 received the most recent grant
    logic              rr_last_q;
`endif

    logic              tie;
    logic              p0_wins_tie;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // State register: INIT after reset, RUN once the fill has finished
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and arbitration; grants are only possible in RUN
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        tie     = bus.p0_req_i & bus.p1_req_i;
`ifdef RAM_ARB_RR_EN
        p0_wins_tie = rr_last_q;
`else
        p0_wins_tie = 1'b1;
`endif
        case (state_q)
            ST_INIT: begin
                if (fill_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.init_done_o) begin
                    gnt0 = bus.p0_req_i & (~tie | p0_wins_tie);
                    gnt1 = bus.p1_req_i & ~gnt0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Mux the winning port's fields toward the RAM registers
    always_comb begin
        any_gnt   = gnt0 | gnt1;
        sel_we    = bus.p0_we_i;
        sel_addr  = bus.p0_addr_i;
        sel_wdata = bus.p0_wdata_i;
        if (gnt1) begin
            sel_we    = bus.p1_we_i;
            sel_addr  = bus.p1_addr_i;
            sel_wdata = bus.p1_wdata_i;
        end
    end

    assign bus.p0_gnt_o = gnt0;
    assign bus.p1_gnt_o = gnt1;

    // Fill counter walks every address once; init_done rises on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q      <= '0;
            bus.init_done_o <= 1'b0;
        end else if (state_q == ST_INIT) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            if (fill_cnt_q == LAST_ADDR) begin
                bus.init_done_o <= 1'b1;
            end
        end
    end

    // RAM control registers: zero writes during the fill, granted access in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_we_o    <= 1'b0;
            bus.ram_addr_o  <= '0;
            bus.ram_wdata_o <= '0;
        end else if (state_q == ST_INIT) begin
            bus.ram_we_o    <= 1'b1;
            bus.ram_addr_o  <= fill_cnt_q;
            bus.ram_wdata_o <= '0;
        end else if (any_gnt) begin
            bus.ram_we_o    <= sel_we;
            bus.ram_addr_o  <= sel_addr;
            bus.ram_wdata_o <= sel_wdata;
        end else begin
            bus.ram_we_o    <= 1'b0;
        end
    end

    // One-cycle pending tag for a granted read, cleared by reset so it is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_port_q  <= 1'b0;
        end else begin
            pend_valid_q <= any_gnt & ~sel_we;
            if (any_gnt) begin
                pend_port_q <= gnt1;
            end
        end
    end

`ifdef RAM_ARB_RR_EN
    // Remember which port won the last grant; reset says p1 so p0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else if (any_gnt) begin
            rr_last_q <= gnt1;
        end
    end
`endif

    // Read return: strobe the tagged port, data gated to zero when not valid
    always_comb begin
        bus.p0_rvalid_o = pend_valid_q & ~pend_port_q;
        bus.p1_rvalid_o = pend_valid_q &  pend_port_q;
        bus.p0_rdata_o  = bus.p0_rvalid_o ? bus.ram_rdata_i : '0;
        bus.p1_rdata_o  = bus.p1_rvalid_o ? bus.ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: bench for ram_arbiter with a behavioural blockram. A
// spec-level model (fill edge count, memory image, pending read) predicts
// every output on every cycle. Directed sequences pin literal values for the
// fill length, read data and tie-break order.
module tb_ram_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // free-running clock, period 10
    always #5 clk = ~clk;

    // cycle counter used to measure grant spacing
    always @(posedge clk) cyc <= cyc + 1;

    // blockram model: negedge read of the old word, then optional write
    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic              ram_seeded = 1'b0;
    always @(negedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] = 16'hDEAD ^ 16'(i);
            ram_seeded = 1'b1;
        end
        bus.ram_rdata_i <= ram_mem[bus.ram_addr_o];
        if (bus.ram_we_o) ram_mem[bus.ram_addr_o] = bus.ram_wdata_o;
    end

    // shared compare task; every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // behavioural model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_edges;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_pv;
    logic              m_pp;
    logic [ADDR_W-1:0] m_paddr;
    logic              m_last;
    logic              e_done, e_g0, e_g1, e_rv0, e_rv1, winner, g_port, g_we;
    logic [DATA_W-1:0] e_rd0, e_rd1, g_data;
    logic [ADDR_W-1:0] g_addr;

    // compare process: predict and check all outputs late in every cycle
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_edges = 0;
                m_we = 1'b0;
                m_addr = '0;
                m_wdata = '0;
                m_pv = 1'b0;
                m_pp = 1'b0;
                m_paddr = '0;
                m_last = 1'b1;
            end
            e_done = (m_edges >= DEPTH);
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (rst_n && e_done) begin
                if (bus.p0_req_i && bus.p1_req_i) begin
`ifdef RAM_ARB_RR_EN
                    winner = ~m_last;
`else
                    winner = 1'b0;
`endif
                    e_g0 = ~winner;
                    e_g1 = winner;
                end else begin
                    e_g0 = bus.p0_req_i;
                    e_g1 = bus.p1_req_i;
                end
            end
            e_rv0 = m_pv & ~m_pp;
            e_rv1 = m_pv & m_pp;
            e_rd0 = e_rv0 ? m_mem[m_paddr] : '0;
            e_rd1 = e_rv1 ? m_mem[m_paddr] : '0;

            checkOutput("init_done", 32'(bus.init_done_o), 32'(e_done));
            checkOutput("p0_gnt", 32'(bus.p0_gnt_o), 32'(e_g0));
            checkOutput("p1_gnt", 32'(bus.p1_gnt_o), 32'(e_g1));
            checkOutput("p0_rvalid", 32'(bus.p0_rvalid_o), 32'(e_rv0));
            checkOutput("p1_rvalid", 32'(bus.p1_rvalid_o), 32'(e_rv1));
            checkOutput("p0_rdata", 32'(bus.p0_rdata_o), 32'(e_rd0));
            checkOutput("p1_rdata", 32'(bus.p1_rdata_o), 32'(e_rd1));
            checkOutput("ram_we", 32'(bus.ram_we_o), 32'(m_we));
            checkOutput("ram_addr", 32'(bus.ram_addr_o), 32'(m_addr));
            checkOutput("ram_wdata", 32'(bus.ram_wdata_o), 32'(m_wdata));

            if (rst_n) begin
                if (m_edges < DEPTH) begin
                    m_edges++;
                    m_we = 1'b1;
                    m_addr = ADDR_W'(m_edges - 1);
                    m_wdata = '0;
                    m_pv = 1'b0;
                    if (m_edges == DEPTH) begin
                        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                    end
                end else if (e_g0 || e_g1) begin
                    g_port = e_g1;
                    g_we   = g_port ? bus.p1_we_i : bus.p0_we_i;
                    g_addr = g_port ? bus.p1_addr_i : bus.p0_addr_i;
                    g_data = g_port ? bus.p1_wdata_i : bus.p0_wdata_i;
                    m_we = g_we;
                    m_addr = g_addr;
                    m_wdata = g_data;
                    if (g_we) m_mem[g_addr] = g_data;
                    m_pv = ~g_we;
                    m_pp = g_port;
                    m_paddr = g_addr;
                    m_last = g_port;
                end else begin
                    m_we = 1'b0;
                    m_pv = 1'b0;
                end
            end
        end
    end

    // step to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // step to the middle of the current cycle, where outputs are settled
    task automatic sampleMid();
        @(negedge clk);
        #1;
    endtask

    // present a single-port request and clear the other port
    task automatic applyStimulus(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data);
        if (port) begin
            bus.p1_req_i = 1'b1; bus.p1_we_i = we; bus.p1_addr_i = addr; bus.p1_wdata_i = data;
            bus.p0_req_i = 1'b0;
        end else begin
            bus.p0_req_i = 1'b1; bus.p0_we_i = we; bus.p0_addr_i = addr; bus.p0_wdata_i = data;
            bus.p1_req_i = 1'b0;
        end
    endtask

    task automatic idle();
        bus.p0_req_i = 1'b0;
        bus.p1_req_i = 1'b0;
    endtask

    // request and wait (bounded) for the grant; returns mid-cycle of the grant
    task automatic issue(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, output longint gcyc);
        logic seen;
        seen = 1'b0;
        gcyc = -1;
        applyStimulus(port, we, addr, data);
        for (int i = 0; i < 20 && !seen; i++) begin
            sampleMid();
            if (port ? bus.p1_gnt_o : bus.p0_gnt_o) begin
                seen = 1'b1;
                gcyc = cyc;
            end else begin
                nextCycle();
            end
        end
        if (!seen) checkOutput("grant_timeout", 32'(0), 32'(1));
    endtask

    // count rising edges after reset release until init_done, bounded
    task automatic waitInit(output int edges, output int we_count);
        edges = 0;
        we_count = 0;
        while (!bus.init_done_o && edges < 5000) begin
            nextCycle();
            edges++;
            if (bus.ram_we_o) we_count++;
        end
    endtask

    // directed sequence with literal expectations
    initial begin
        int     edges, we_count;
        longint g1, g2;
        logic   tie_g0 [6];
        logic   tie_g1 [6];

        bus.p0_req_i = 1'b0; bus.p0_we_i = 1'b0; bus.p0_addr_i = '0; bus.p0_wdata_i = '0;
        bus.p1_req_i = 1'b0; bus.p1_we_i = 1'b0; bus.p1_addr_i = '0; bus.p1_wdata_i = '0;
        rst_n = 1'b0;
        repeat (3) nextCycle();
        sampleMid();
        checkOutput("reset_init_done", 32'(bus.init_done_o), 32'(0));
        checkOutput("reset_ram_we", 32'(bus.ram_we_o), 32'(0));
        checkOutput("reset_ram_addr", 32'(bus.ram_addr_o), 32'(0));
        checkOutput("reset_p0_rvalid", 32'(bus.p0_rvalid_o), 32'(0));

        // zero-fill then read an untouched address
        nextCycle();
        rst_n = 1'b1;
        waitInit(edges, we_count);
        checkOutput("fill_cycles", 32'(edges), 32'(4096));
        checkOutput("fill_we_cycles", 32'(we_count), 32'(4096));
        issue(1'b1, 1'b0, 12'hABC, 16'h0, g1);
        nextCycle();
        idle();
        sampleMid();
        checkOutput("fill_read_rvalid", 32'(bus.p1_rvalid_o), 32'(1));
        checkOutput("fill_read_data", 32'(bus.p1_rdata_o), 32'h0000);
        nextCycle();

        // write then read on p0 in consecutive cycles
        issue(1'b0, 1'b1, 12'h010, 16'hBEEF, g1);
        nextCycle();
        issue(1'b0, 1'b0, 12'h010, 16'h0, g2);
        checkOutput("wr_rd_spacing", 32'(g2 - g1), 32'(1));
        nextCycle();
        idle();
        sampleMid();
        checkOutput("wr_rd_rvalid", 32'(bus.p0_rvalid_o), 32'(1));
        checkOutput("wr_rd_data", 32'(bus.p0_rdata_o), 32'hBEEF);
        checkOutput("wr_rd_p1_quiet", 32'(bus.p1_rvalid_o), 32'(0));
        nextCycle();

        // p1 write then p0 read of the same address back to back
        issue(1'b1, 1'b1, 12'h3FF, 16'h1234, g1);
        nextCycle();
        issue(1'b0, 1'b0, 12'h3FF, 16'h0, g2);
        checkOutput("b2b_spacing", 32'(g2 - g1), 32'(1));
        nextCycle();
        idle();
        sampleMid();
        checkOutput("b2b_data", 32'(bus.p0_rdata_o), 32'h1234);
        nextCycle();

        // p1 read so that p1 holds the last grant before the tie
        issue(1'b1, 1'b0, 12'h010, 16'h0, g1);
        nextCycle();
        idle();
        sampleMid();
        checkOutput("p1_read_data", 32'(bus.p1_rdata_o), 32'hBEEF);
        nextCycle();

        // persistent tie of reads for six cycles
        bus.p0_we_i = 1'b0; bus.p0_addr_i = 12'h010;
        bus.p1_we_i = 1'b0; bus.p1_addr_i = 12'h3FF;
        bus.p0_req_i = 1'b1; bus.p1_req_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sampleMid();
            tie_g0[i] = bus.p0_gnt_o;
            tie_g1[i] = bus.p1_gnt_o;
            nextCycle();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_RR_EN
            checkOutput($sformatf("tie_p0_gnt_%0d", i), 32'(tie_g0[i]), 32'((i % 2) == 0));
            checkOutput($sformatf("tie_p1_gnt_%0d", i), 32'(tie_g1[i]), 32'((i % 2) == 1));
`else
            checkOutput($sformatf("tie_p0_gnt_%0d", i), 32'(tie_g0[i]), 32'(1));
            checkOutput($sformatf("tie_p1_gnt_%0d", i), 32'(tie_g1[i]), 32'(0));
`endif
        end
        sampleMid();
        nextCycle();

        // reset with a read pending: no strobe, and memory is zero afterwards
        issue(1'b0, 1'b0, 12'h010, 16'h0, g1);
        nextCycle();
        rst_n = 1'b0;
        idle();
        sampleMid();
        checkOutput("pend_reset_rvalid", 32'(bus.p0_rvalid_o), 32'(0));
        checkOutput("pend_reset_init_done", 32'(bus.init_done_o), 32'(0));
        nextCycle();
        sampleMid();
        checkOutput("pend_reset_rvalid_hold", 32'(bus.p0_rvalid_o), 32'(0));
        nextCycle();
        rst_n = 1'b1;
        waitInit(edges, we_count);
        checkOutput("refill_cycles", 32'(edges), 32'(4096));
        issue(1'b0, 1'b0, 12'h010, 16'h0, g1);
        nextCycle();
        idle();
        sampleMid();
        checkOutput("refill_rvalid", 32'(bus.p0_rvalid_o), 32'(1));
        checkOutput("refill_data", 32'(bus.p0_rdata_o), 32'h0000);

        // reset in the middle of the fill (counter at 100)
        nextCycle();
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        repeat (100) nextCycle();
        checkOutput("midfill_addr", 32'(bus.ram_addr_o), 32'(99));
        rst_n = 1'b0;
        #1;
        checkOutput("midfill_reset_we", 32'(bus.ram_we_o), 32'(0));
        checkOutput("midfill_reset_addr", 32'(bus.ram_addr_o), 32'(0));
        nextCycle();
        rst_n = 1'b1;
        waitInit(edges, we_count);
        checkOutput("midfill_refill_cycles", 32'(edges), 32'(4096));
        checkOutput("midfill_refill_we", 32'(we_count), 32'(4096));
        repeat (2) nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
